// File: rtl/moving_average_decoder_pkg.sv
// moving_average_decoder_pkg: shared widths, types and saturation for the averaging/decoding path
package moving_average_decoder_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int WIN_N_DEF  = 4;

    function automatic int sum_width(input int data_w, input int win_n);
        return data_w + $clog2(win_n);
    endfunction

    typedef logic signed [DATA_W_DEF-1:0]                            sample_t;
    typedef logic signed [sum_width(DATA_W_DEF, WIN_N_DEF)-1:0]      sum_t;

    typedef enum logic {
        FILLING = 1'b0,
        PRIMED  = 1'b1
    } fill_state_e;

    // Clamp a wide signed value into the signed range of a data_w-bit sample.
    function automatic int saturate(input int d, input int data_w);
        int mx;
        int mn;
        mx = (1 <<< (data_w - 1)) - 1;
        mn = -mx - 1;
        return (d > mx) ? mx : (d < mn) ? mn : d;
    endfunction

endpackage

// File: rtl/moving_average_decoder_sample_history_ring.sv
// sample_history_ring: WIN_N-deep ring of emitted samples, read-before-write with sync clear
module sample_history_ring #(
    parameter int DATA_W = 8,
    parameter int WIN_N  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int PTR_W = $clog2(WIN_N);

    logic [DATA_W-1:0] ring_q [WIN_N];
    logic [DATA_W-1:0] ring_d [WIN_N];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  wptr_d;
    logic [PTR_W-1:0]  base;

    // The slot under the pointer holds x[n-N]; a clear makes the whole history read as zero.
    assign rdata_o = clear_i ? '0 : ring_q[wptr_q];

    // Clear first, then write the new sample at the (possibly restarted) pointer and advance it.
    always_comb begin
        base = clear_i ? '0 : wptr_q;
        for (int i = 0; i < WIN_N; i++) ring_d[i] = clear_i ? '0 : ring_q[i];
        wptr_d = base;
        if (we_i) begin
            ring_d[base] = wdata_i;
            wptr_d       = base + PTR_W'(1);
        end
    end

    // Ring storage and write pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIN_N; i++) ring_q[i] <= '0;
            wptr_q <= '0;
        end else begin
            for (int i = 0; i < WIN_N; i++) ring_q[i] <= ring_d[i];
            wptr_q <= wptr_d;
        end
    end

endmodule

// File: rtl/moving_average_decoder.sv
// moving_average_decoder: rebuilds x[n] = S[n] - S[n-1] + x[n-N] from a window-sum stream
module moving_average_decoder
    import moving_average_decoder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WIN_N  = WIN_N_DEF
) (
    input  logic                                  system1000,
    input  logic                                  system1000_rst,
    input  logic [sum_width(DATA_W, WIN_N)-1:0]   sum_i,
    input  logic                                  sum_valid_i,
    input  logic                                  clear_i,
    output logic [DATA_W-1:0]                     sample_o,
    output logic                                  sample_valid_o,
    output logic                                  primed_o,
    output logic                                  overflow_o
);

    localparam int SUM_W = sum_width(DATA_W, WIN_N);
    localparam int CNT_W = $clog2(WIN_N) + 1;

    logic signed [SUM_W-1:0]  prev_sum_q, prev_sum_d, prev_eff;
    logic [DATA_W-1:0]        sample_q, sample_d, sat_sample, ring_rd;
    logic                     valid_q, valid_d;
    logic                     overflow_q, overflow_d;
    logic [CNT_W-1:0]         count_q, count_d, count_base;
    fill_state_e              state_q, state_d;
    logic signed [SUM_W+1:0]  d;
    int                       d_ext;
    int                       sat;
    logic                     sat_hit;

    sample_history_ring #(
        .DATA_W (DATA_W),
        .WIN_N  (WIN_N)
    ) u_ring (
        .clk     (system1000),
        .rst     (system1000_rst),
        .clear_i (clear_i),
        .we_i    (sum_valid_i),
        .wdata_i (sat_sample),
        .rdata_o (ring_rd)
    );

    // Difference-plus-history in a widened signed domain, then clamp to the sample range.
    always_comb begin
        prev_eff   = clear_i ? '0 : prev_sum_q;
        d          = (SUM_W+2)'($signed(sum_i)) - (SUM_W+2)'(prev_eff) + (SUM_W+2)'($signed(ring_rd));
        d_ext      = int'(d);
        sat        = saturate(d_ext, DATA_W);
        sat_hit    = sat != d_ext;
        sat_sample = DATA_W'(sat);
    end

    // Next-state: clear restarts history before an accompanying sample is processed; fill FSM tracks priming.
    always_comb begin
        sample_d   = sample_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;
        prev_sum_d = prev_eff;
        count_base = clear_i ? '0 : count_q;
        count_d    = count_base;
        state_d    = clear_i ? FILLING : state_q;
        if (sum_valid_i) begin
            sample_d   = sat_sample;
            valid_d    = 1'b1;
            overflow_d = overflow_q | sat_hit;
            prev_sum_d = $signed(sum_i);
            count_d    = (count_base == CNT_W'(WIN_N)) ? count_base : count_base + CNT_W'(1);
            state_d    = (state_d == FILLING && count_d == CNT_W'(WIN_N)) ? PRIMED : state_d;
        end
    end

    // State registers; reset overrides every other input.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            prev_sum_q <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            state_q    <= FILLING;
        end else begin
            prev_sum_q <= prev_sum_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            state_q    <= state_d;
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign overflow_o     = overflow_q;
    assign primed_o       = state_q == PRIMED;

endmodule

// File: tb/tb_moving_average_decoder.sv
// tb_moving_average_decoder: scoreboard bench against a sample-history reference model
module tb_moving_average_decoder;

    localparam int DW  = 8;
    localparam int WIN = 4;
    localparam int SW  = DW + $clog2(WIN);

    logic          system1000 = 1'b0;
    logic          system1000_rst = 1'b1;
    logic [SW-1:0] sum_i = '0;
    logic          sum_valid_i = 1'b0;
    logic          clear_i = 1'b0;
    logic [DW-1:0] sample_o;
    logic          sample_valid_o;
    logic          primed_o;
    logic          overflow_o;

    moving_average_decoder #(.DATA_W(DW), .WIN_N(WIN)) dut (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .sum_i          (sum_i),
        .sum_valid_i    (sum_valid_i),
        .clear_i        (clear_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .primed_o       (primed_o),
        .overflow_o     (overflow_o)
    );

    always #5 system1000 = ~system1000;

    typedef struct {
        int sample;
        bit primed;
        bit ovf;
    } exp_t;

    exp_t sb[$];
    int   hist[$];
    int   m_prev;
    int   m_cnt;
    bit   m_ovf;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: x[n] = S[n] - S[n-1] + (sample emitted N accepts ago), saturated; history is the list of emitted samples.
    task automatic model(input bit r, input bit v, input bit c, input int s);
        int x;
        int y;
        int back;
        if (r) begin
            hist.delete();
            m_prev = 0;
            m_cnt  = 0;
            m_ovf  = 0;
            return;
        end
        if (c) begin
            hist.delete();
            m_prev = 0;
            m_cnt  = 0;
        end
        if (v) begin
            back = (hist.size() >= WIN) ? hist[hist.size() - WIN] : 0;
            x = s - m_prev + back;
            y = (x > 127) ? 127 : (x < -128) ? -128 : x;
            if (y != x) m_ovf = 1;
            hist.push_back(y);
            m_prev = s;
            if (m_cnt < WIN) m_cnt++;
            sb.push_back('{y, m_cnt == WIN, m_ovf});
        end
    endtask

    task automatic step(input bit r, input bit v, input bit c, input int s);
        logic signed [SW-1:0] t;
        t = SW'(s);
        system1000_rst = r;
        sum_valid_i    = v;
        clear_i        = c;
        sum_i          = t;
        model(r, v, c, int'(t));
        @(posedge system1000);
        #1;
        system1000_rst = 1'b0;
        sum_valid_i    = 1'b0;
        clear_i        = 1'b0;
    endtask

    task automatic check_idle(input string name, input int s, input bit p, input bit o);
        chk({name, "_valid"}, int'(sample_valid_o), 0);
        chk({name, "_sample"}, int'($signed(sample_o)), s);
        chk({name, "_primed"}, int'(primed_o), int'(p));
        chk({name, "_overflow"}, int'(overflow_o), int'(o));
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge system1000) begin
        if (sample_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got sample %0d with no expectation at %0t", $signed(sample_o), $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sample", int'($signed(sample_o)), e.sample);
                chk("primed", int'(primed_o), int'(e.primed));
                chk("overflow", int'(overflow_o), int'(e.ovf));
            end
        end
    end

    initial begin
        int ramp[6];
        int gq[$];
        int gsum;
        int s;
        bit v;
        bit c;
        ramp = '{1, 3, 6, 10, 14, 18};

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_idle("reset", 0, 0, 0);

        foreach (ramp[i]) step(0, 1, 0, ramp[i]);
        step(0, 0, 0, 0);
        check_idle("ramp_hold", 6, 1, 0);

        step(1, 0, 0, 0);
        step(0, 1, 0, -128);
        step(0, 1, 0, -256);
        step(0, 1, 0, -384);
        step(0, 1, 0, -512);
        step(0, 1, 0, -512);

        step(1, 0, 0, 0);
        foreach (ramp[i]) begin
            step(0, 1, 0, ramp[i]);
            step(0, 0, 0, 0);
            step(0, 0, 0, 0);
        end

        step(1, 0, 0, 0);
        step(0, 1, 0, 200);
        step(0, 0, 1, 0);
        check_idle("clear_keeps_ovf", 127, 0, 1);
        step(0, 1, 0, 5);
        step(0, 1, 0, 11);
        step(1, 0, 0, 0);
        check_idle("reset_clears_ovf", 0, 0, 0);

        for (int i = 0; i < 5; i++) step(0, 1, 0, ramp[i]);
        step(0, 1, 1, 7);
        step(0, 1, 0, 9);
        step(0, 1, 0, 12);
        step(0, 1, 0, 16);
        step(0, 0, 1, 0);
        check_idle("clear_unprimes", 4, 0, 0);

        step(0, 1, 0, 1);
        step(0, 1, 0, 3);
        step(1, 1, 0, 6);
        check_idle("reset_midstream", 0, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 3);
        step(0, 1, 0, 6);

        gq = '{0, 0, 0, 0};
        gsum = 0;
        for (int i = 0; i < 600; i++) begin
            v = $urandom_range(0, 9) < 7;
            c = $urandom_range(0, 24) == 0;
            if (c) begin
                gq = '{0, 0, 0, 0};
                gsum = 0;
            end
            if ($urandom_range(0, 4) == 0) begin
                s = int'($urandom_range(0, 1023)) - 512;
            end else begin
                if (v) begin
                    int x;
                    x = int'($urandom_range(0, 255)) - 128;
                    gsum = gsum + x - gq.pop_front();
                    gq.push_back(x);
                end
                s = gsum;
            end
            step(0, v, c, s);
        end

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
